// File: rtl/data_mem_resp_if.sv
// Load/store request bus between the MEM stage (master) and the data memory responder (slave).
interface data_mem_resp_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ack_o;
    logic        err_o;
    logic        stall_req_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, mem_ack_o, err_o, stall_req_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, mem_ack_o, err_o, stall_req_o
    );
endinterface

// File: rtl/data_mem_resp.sv
// Word-addressed data memory responder: programmable wait states, byte-lane stores,
// registered load data, out-of-range error and a stall request while busy.
module data_mem_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_resp_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t              state, state_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic                accept, commit;

    logic                req_we;
    logic [ADDR_W-1:0]   req_idx;
    logic [3:0]          req_sel;
    logic [31:0]         req_wdata;
    logic                req_err;

    logic                c_we;
    logic [ADDR_W-1:0]   c_idx;
    logic [3:0]          c_sel;
    logic [31:0]         c_wdata;
    logic                c_err;

    logic [ADDR_W-1:0]   in_idx;
    logic                in_err;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    logic [31:0]         data_q;
    logic                ack_q;
    logic                err_q;

    assign in_idx = bus.mem_addr_i[ADDR_W+1:2];
    assign in_err = |bus.mem_addr_i[31:ADDR_W+2];

    // With zero wait states the commit happens on the accepting edge, so the
    // commit path takes fields straight from the bus while in IDLE.
    always_comb begin
        if (state == IDLE) begin
            c_we    = bus.mem_we_i;
            c_idx   = in_idx;
            c_sel   = bus.mem_sel_i;
            c_wdata = bus.mem_data_i;
            c_err   = in_err;
        end else begin
            c_we    = req_we;
            c_idx   = req_idx;
            c_sel   = req_sel;
            c_wdata = req_wdata;
            c_err   = req_err;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_ce_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = 3'(WAIT_CYCLES - 1);
                    end
                end
            end
            BUSY: begin
                if (!bus.mem_ce_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ACK;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_we    <= 1'b0;
            req_idx   <= '0;
            req_sel   <= '0;
            req_wdata <= '0;
            req_err   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_we    <= bus.mem_we_i;
                req_idx   <= in_idx;
                req_sel   <= bus.mem_sel_i;
                req_wdata <= bus.mem_data_i;
                req_err   <= in_err;
            end
            ack_q <= commit;
            err_q <= commit & c_err;
            if (commit) begin
                if (c_err)
                    data_q <= '0;
                else if (!c_we)
                    data_q <= mem[c_idx];
            end
        end
    end

    // Array is never reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && commit && c_we && !c_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (c_sel[b])
                    mem[c_idx][b*8 +: 8] <= c_wdata[b*8 +: 8];
            end
        end
    end

    assign bus.mem_data_o  = data_q;
    assign bus.mem_ack_o   = ack_q;
    assign bus.err_o       = err_q;
    assign bus.stall_req_o = bus.mem_ce_i & (state != ACK);
endmodule
